// File: rtl/clk_div_ctrl.sv
// Divides clk into clk_out with four preset half-periods, glitch-free freq switch, halt handshake and rise strobe.
// Single-step operation while halted is compiled in only when CLK_STEP_EN is defined.
module clk_div_ctrl #(
    parameter int unsigned        CNT_W = 32,
    parameter logic [CNT_W-1:0]   DIV0  = 2500,
    parameter logic [CNT_W-1:0]   DIV1  = 25000000,
    parameter logic [CNT_W-1:0]   DIV2  = 2500000,
    parameter logic [CNT_W-1:0]   DIV3  = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] freq,
    input  logic       halt_req,
    input  logic       step,
    output logic       clk_out,
    output logic       clk_rise,
    output logic       halted
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
`ifdef CLK_STEP_EN
        STEP   = 2'd2,
`endif
        HALTED = 2'd1
    } state_t;

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state, state_n;
    logic [CNT_W-1:0] count, count_n;
    logic [CNT_W-1:0] div_q, div_q_n;
    logic [CNT_W-1:0] div_sel;
    logic             clk_out_n;
    logic             clk_rise_n;
    logic             terminal;

    always_comb begin
        div_sel = DIV0;
        case (freq)
            2'b00:   div_sel = DIV0;
            2'b01:   div_sel = DIV1;
            2'b10:   div_sel = DIV2;
            default: div_sel = DIV3;
        endcase
    end

    assign terminal = (count == div_q);

    always_comb begin
        state_n    = state;
        count_n    = count;
        div_q_n    = div_q;
        clk_out_n  = clk_out;
        clk_rise_n = 1'b0;
        case (state)
            RUN: begin
                // A pending halt waits for the high phase so clk_out only ever freezes high.
                if (halt_req && clk_out) begin
                    state_n = HALTED;
                    count_n = '0;
                end else if (terminal) begin
                    count_n    = '0;
                    clk_out_n  = ~clk_out;
                    clk_rise_n = ~clk_out;
                    div_q_n    = div_sel;
                end else begin
                    count_n = count + ONE;
                end
            end
            HALTED: begin
                if (!halt_req) begin
                    state_n = RUN;
                    count_n = '0;
                    div_q_n = div_sel;
`ifdef CLK_STEP_EN
                end else if (step) begin
                    state_n   = STEP;
                    count_n   = '0;
                    clk_out_n = 1'b0;
                    div_q_n   = div_sel;
`endif
                end
            end
`ifdef CLK_STEP_EN
            STEP: begin
                if (terminal) begin
                    state_n    = HALTED;
                    count_n    = '0;
                    clk_out_n  = 1'b1;
                    clk_rise_n = 1'b1;
                    div_q_n    = div_sel;
                end else begin
                    count_n = count + ONE;
                end
            end
`endif
            default: state_n = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= RUN;
            count    <= '0;
            div_q    <= DIV0;
            clk_out  <= 1'b0;
            clk_rise <= 1'b0;
        end else begin
            state    <= state_n;
            count    <= count_n;
            div_q    <= div_q_n;
            clk_out  <= clk_out_n;
            clk_rise <= clk_rise_n;
        end
    end

`ifdef CLK_STEP_EN
    // A single step is part of the halted episode, so status stays asserted through it.
    assign halted = (state == HALTED) || (state == STEP);
`else
    assign halted = (state == HALTED);
    logic unused_step;
    assign unused_step = step;
`endif

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed self-checking bench for clk_div_ctrl with DIV0=3, DIV1=1, DIV2=5, DIV3=0.
module tb_clk_div_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] freq;
    logic       halt_req;
    logic       step;
    logic       clk_out;
    logic       clk_rise;
    logic       halted;

    int errors = 0;
    int checks = 0;

    clk_div_ctrl #(
        .CNT_W (32),
        .DIV0  (32'd3),
        .DIV1  (32'd1),
        .DIV2  (32'd5),
        .DIV3  (32'd0)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .freq     (freq),
        .halt_req (halt_req),
        .step     (step),
        .clk_out  (clk_out),
        .clk_rise (clk_rise),
        .halted   (halted)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk3(input string tag, input logic e_out, input logic e_rise, input logic e_halt);
        chk({tag, ".clk_out"},  clk_out,  e_out);
        chk({tag, ".clk_rise"}, clk_rise, e_rise);
        chk({tag, ".halted"},   halted,   e_halt);
    endtask

    initial begin
        reset    = 1'b0;
        freq     = 2'b00;
        halt_req = 1'b0;
        step     = 1'b0;
        #3;
        chk3("reset", 1'b0, 1'b0, 1'b0);
        tick();
        reset = 1'b1;

        // T1: period 8, rise every 8 clk
        for (int k = 1; k <= 16; k++) begin
            tick();
            chk3($sformatf("t1.k%0d", k), ((k / 4) % 2) == 1, (k % 8) == 4, 1'b0);
        end

        // T2: freq=01 at count=1 of a low phase
        tick();
        chk3("t2.k17", 1'b0, 1'b0, 1'b0);
        freq = 2'b01;
        for (int k = 18; k <= 29; k++) begin
            tick();
            if (k < 20)
                chk3($sformatf("t2.k%0d", k), 1'b0, 1'b0, 1'b0);
            else
                chk3($sformatf("t2.k%0d", k), (((k - 20) / 2) % 2) == 0, ((k - 20) % 4) == 0, 1'b0);
        end
        freq = 2'b00;
        tick();
        chk3("t2.k30", 1'b0, 1'b0, 1'b0);

        // T3: halt raised at count=0 of a low phase
        halt_req = 1'b1;
        for (int k = 31; k <= 33; k++) begin
            tick();
            chk3($sformatf("t3.k%0d", k), 1'b0, 1'b0, 1'b0);
        end
        tick();
        chk3("t3.rise", 1'b1, 1'b1, 1'b0);
        for (int k = 35; k <= 38; k++) begin
            tick();
            chk3($sformatf("t3.hold%0d", k), 1'b1, 1'b0, 1'b1);
        end

`ifdef CLK_STEP_EN
        // T4: one step pulse gives one low phase and one rise
        step = 1'b1;
        tick();
        step = 1'b0;
        chk3("t4.k39", 1'b0, 1'b0, 1'b1);
        for (int k = 40; k <= 42; k++) begin
            tick();
            chk3($sformatf("t4.k%0d", k), 1'b0, 1'b0, 1'b1);
        end
        tick();
        chk3("t4.rise", 1'b1, 1'b1, 1'b1);
        tick();
        chk3("t4.back", 1'b1, 1'b0, 1'b1);
`else
        // T6: step ignored while halted
        for (int k = 39; k <= 44; k++) begin
            step = (k % 2) == 1;
            tick();
            chk3($sformatf("t6.k%0d", k), 1'b1, 1'b0, 1'b1);
        end
        step = 1'b0;
`endif

        // halt_req fall together with step: RUN wins, full high phase follows
        halt_req = 1'b0;
        step     = 1'b1;
        tick();
        step = 1'b0;
        chk3("t3.resume", 1'b1, 1'b0, 1'b0);
        for (int k = 46; k <= 47; k++) begin
            tick();
            chk3($sformatf("t3.high%0d", k), 1'b1, 1'b0, 1'b0);
        end
        freq = 2'b11;
        tick();
        chk3("t3.high48", 1'b1, 1'b0, 1'b0);
        tick();
        chk3("t3.fall", 1'b0, 1'b0, 1'b0);

        // T5: DIV3=0 toggles every clk
        for (int k = 50; k <= 54; k++) begin
            tick();
            chk3($sformatf("t5.k%0d", k), (k % 2) == 0, (k % 2) == 0, 1'b0);
        end
        #2;
        reset = 1'b0;
        #1;
        chk3("t5.async_rst", 1'b0, 1'b0, 1'b0);
        tick();
        reset = 1'b1;

        // async reset while halted
        freq     = 2'b00;
        halt_req = 1'b1;
        for (int k = 1; k <= 5; k++) tick();
        chk3("rst_halt.pre", 1'b1, 1'b0, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        chk3("rst_halt.async", 1'b0, 1'b0, 1'b0);
        tick();
        halt_req = 1'b0;
        reset    = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk3($sformatf("rst_halt.k%0d", k), k == 4, k == 4, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
